// File: rtl/image_proc_ctrl.sv
// Frame-level sequencer for the grayscale/Sobel datapath: aligns processing to frame-valid,
// commits display mode per frame, masks 3x3 border strobes and reports per-frame status.
module image_proc_ctrl #(
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480,
    parameter int KSIZE     = 3,
    parameter int FLUSH_CYC = 4
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iEN,
    input  logic        iFVAL,
    input  logic        iWIN_DVAL,
    input  logic        iMODE_WR,
    input  logic [1:0]  iMODE_REQ,
    output logic [1:0]  oMODE,
    output logic        oPROC_EN,
    output logic        oOUT_DVAL,
    output logic        oBORDER,
    output logic [10:0] oCOL,
    output logic [10:0] oROW,
    output logic        oFRAME_DONE,
    output logic [15:0] oFRAME_CNT,
    output logic        oERR
);

    localparam int              FW         = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [FW-1:0]   FLUSH_LOAD = FW'(FLUSH_CYC - 1);
    localparam logic [10:0]     COL_LAST   = 11'(IMG_W - 1);
    localparam logic [10:0]     ROW_LAST   = 11'(IMG_H - 1);
    localparam logic [10:0]     EDGE_LIM   = 11'(KSIZE - 1);
    localparam logic [1:0]      MODE_ILL   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_ACTIVE,
        S_FLUSH
    } state_t;

    state_t          state, state_nxt;
    logic            fval_d;
    logic            fval_rise, fval_fall;
    logic [1:0]      mode_pend;
    logic [10:0]     col, row;
    logic            full;
    logic [FW-1:0]   flush_cnt;
    logic            in_frame, strobe, accepted, overflow, interior;
    logic            frame_start, flush_load, flush_end;

    assign fval_rise = iFVAL & ~fval_d;
    assign fval_fall = ~iFVAL & fval_d;

    assign in_frame  = (state == S_ACTIVE) || (state == S_FLUSH);
    assign strobe    = in_frame & iWIN_DVAL;
    assign accepted  = strobe & ~full;
    assign overflow  = strobe & full;
    assign interior  = (col >= EDGE_LIM) && (row >= EDGE_LIM);
    assign oPROC_EN  = in_frame;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        frame_start = 1'b0;
        flush_load  = 1'b0;
        flush_end   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (iEN) state_nxt = S_ARMED;
            end
            S_ARMED: begin
                if (!iEN) begin
                    state_nxt = S_IDLE;
                end else if (fval_rise) begin
                    state_nxt   = S_ACTIVE;
                    frame_start = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (fval_fall) begin
                    state_nxt  = S_FLUSH;
                    flush_load = 1'b1;
                end
            end
            S_FLUSH: begin
                if (flush_cnt == '0) begin
                    flush_end = 1'b1;
                    state_nxt = iEN ? S_ARMED : S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // fval_d resets high so a frame already in progress at reset release is not taken as a start.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            fval_d    <= 1'b1;
            mode_pend <= 2'd0;
            oMODE     <= 2'd0;
        end else begin
            fval_d <= iFVAL;
            if (iMODE_WR && (iMODE_REQ != MODE_ILL)) mode_pend <= iMODE_REQ;
            if (frame_start) oMODE <= mode_pend;
        end
    end

    // Window position of the next accepted strobe; full marks the last pixel as consumed.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            col  <= '0;
            row  <= '0;
            full <= 1'b0;
        end else if (frame_start) begin
            col  <= '0;
            row  <= '0;
            full <= 1'b0;
        end else if (accepted) begin
            if (col == COL_LAST) begin
                if (row == ROW_LAST) begin
                    full <= 1'b1;
                end else begin
                    col <= '0;
                    row <= row + 11'd1;
                end
            end else begin
                col <= col + 11'd1;
            end
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            flush_cnt <= '0;
        end else if (flush_load) begin
            flush_cnt <= FLUSH_LOAD;
        end else if ((state == S_FLUSH) && (flush_cnt != '0)) begin
            flush_cnt <= flush_cnt - 1'b1;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oOUT_DVAL <= 1'b0;
            oBORDER   <= 1'b0;
            oCOL      <= '0;
            oROW      <= '0;
        end else begin
            oOUT_DVAL <= accepted & interior;
            oBORDER   <= accepted & ~interior;
            if (accepted) begin
                oCOL <= col;
                oROW <= row;
            end
        end
    end

    // A frame that ends without filling every window position is flagged as short.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oFRAME_DONE <= 1'b0;
            oFRAME_CNT  <= '0;
            oERR        <= 1'b0;
        end else begin
            oFRAME_DONE <= flush_end;
            if (flush_end) oFRAME_CNT <= oFRAME_CNT + 16'd1;
            if (overflow || (flush_end && !full)) oERR <= 1'b1;
        end
    end

endmodule

// File: tb/tb_image_proc_ctrl.sv
// Bench for image_proc_ctrl: frame-level reference model compared every cycle,
// plus directed frames with hand-computed literal expectations.
module tb_image_proc_ctrl;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int K  = 3;
    localparam int FC = 2;

    logic        iCLK, iRST, iEN, iFVAL, iWIN_DVAL, iMODE_WR;
    logic [1:0]  iMODE_REQ;
    logic [1:0]  oMODE;
    logic        oPROC_EN, oOUT_DVAL, oBORDER, oFRAME_DONE, oERR;
    logic [10:0] oCOL, oROW;
    logic [15:0] oFRAME_CNT;

    image_proc_ctrl #(.IMG_W(W), .IMG_H(H), .KSIZE(K), .FLUSH_CYC(FC)) dut (
        .iCLK(iCLK), .iRST(iRST), .iEN(iEN), .iFVAL(iFVAL), .iWIN_DVAL(iWIN_DVAL),
        .iMODE_WR(iMODE_WR), .iMODE_REQ(iMODE_REQ), .oMODE(oMODE), .oPROC_EN(oPROC_EN),
        .oOUT_DVAL(oOUT_DVAL), .oBORDER(oBORDER), .oCOL(oCOL), .oROW(oROW),
        .oFRAME_DONE(oFRAME_DONE), .oFRAME_CNT(oFRAME_CNT), .oERR(oERR)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame phases, a pixel index k mapped to (k%W, k/W), a flush countdown.
    typedef enum int {P_IDLE, P_ARMED, P_ACTIVE, P_FLUSH} phase_t;
    phase_t      ph;
    logic        m_fprev;
    logic [1:0]  m_pend;
    int          m_k;
    int          m_left;
    logic [1:0]  e_mode;
    logic        e_dval, e_border, e_done, e_err;
    logic [10:0] e_col, e_row;
    logic [15:0] e_cnt;

    always @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            ph = P_IDLE; m_fprev = 1'b1; m_pend = 2'd0; m_k = 0; m_left = 0;
            e_mode = 2'd0; e_dval = 1'b0; e_border = 1'b0; e_done = 1'b0; e_err = 1'b0;
            e_col = '0; e_row = '0; e_cnt = '0;
        end else begin
            automatic logic rise = iFVAL && !m_fprev;
            automatic logic fall = !iFVAL && m_fprev;
            m_fprev  = iFVAL;
            e_dval   = 1'b0;
            e_border = 1'b0;
            e_done   = 1'b0;
            if ((ph == P_ACTIVE || ph == P_FLUSH) && iWIN_DVAL) begin
                if (m_k < W * H) begin
                    e_col = 11'(m_k % W);
                    e_row = 11'(m_k / W);
                    if ((m_k % W) >= K - 1 && (m_k / W) >= K - 1) e_dval = 1'b1;
                    else e_border = 1'b1;
                    m_k++;
                end else begin
                    e_err = 1'b1;
                end
            end
            case (ph)
                P_IDLE:   if (iEN) ph = P_ARMED;
                P_ARMED:  if (!iEN) ph = P_IDLE;
                          else if (rise) begin ph = P_ACTIVE; e_mode = m_pend; m_k = 0; end
                P_ACTIVE: if (fall) begin ph = P_FLUSH; m_left = FC; end
                P_FLUSH: begin
                    m_left--;
                    if (m_left == 0) begin
                        e_done = 1'b1;
                        e_cnt  = e_cnt + 16'd1;
                        if (m_k != W * H) e_err = 1'b1;
                        ph = iEN ? P_ARMED : P_IDLE;
                    end
                end
                default: ph = P_IDLE;
            endcase
            if (iMODE_WR && iMODE_REQ != 2'd3) m_pend = iMODE_REQ;
        end
    end

    always @(negedge iCLK) begin
        check("oMODE", 32'(oMODE), 32'(e_mode));
        check("oPROC_EN", 32'(oPROC_EN), 32'(ph == P_ACTIVE || ph == P_FLUSH));
        check("oOUT_DVAL", 32'(oOUT_DVAL), 32'(e_dval));
        check("oBORDER", 32'(oBORDER), 32'(e_border));
        check("oCOL", 32'(oCOL), 32'(e_col));
        check("oROW", 32'(oROW), 32'(e_row));
        check("oFRAME_DONE", 32'(oFRAME_DONE), 32'(e_done));
        check("oFRAME_CNT", 32'(oFRAME_CNT), 32'(e_cnt));
        check("oERR", 32'(oERR), 32'(e_err));
    end

    // Direct tallies of DUT outputs for the literal per-frame expectations.
    int          n_dval, n_border, done_ticks, pe_seen;
    logic [21:0] coords[$];
    logic [1:0]  mode_seen;
    logic        err_pre;

    task automatic tick();
        @(posedge iCLK);
        #1;
        if (oOUT_DVAL) begin
            n_dval++;
            coords.push_back({oCOL, oROW});
        end
        if (oBORDER) n_border++;
        if (oPROC_EN) pe_seen++;
    endtask

    task automatic clear_tally();
        n_dval = 0; n_border = 0; pe_seen = 0;
        coords.delete();
    endtask

    // n strobes; optional mode write at strobe 3 and at the rise edge; optional iEN drop at strobe en_drop.
    task automatic run_frame(input int n, input int mid_wr, input int rise_wr, input int en_drop);
        bit seen;
        clear_tally();
        iFVAL = 1'b1;
        if (rise_wr >= 0) begin
            iMODE_WR  = 1'b1;
            iMODE_REQ = 2'(rise_wr);
        end
        tick();
        iMODE_WR  = 1'b0;
        mode_seen = oMODE;
        for (int i = 0; i < n; i++) begin
            iWIN_DVAL = 1'b1;
            iMODE_WR  = 1'b0;
            if (i == 3 && mid_wr >= 0) begin
                iMODE_WR  = 1'b1;
                iMODE_REQ = 2'(mid_wr);
            end
            if (i == en_drop) iEN = 1'b0;
            tick();
        end
        iWIN_DVAL = 1'b0;
        iMODE_WR  = 1'b0;
        tick();
        err_pre = oERR;
        iFVAL = 1'b0;
        seen = 1'b0;
        done_ticks = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            done_ticks++;
            if (oFRAME_DONE) seen = 1'b1;
        end
        check("frame_done_seen", 32'(seen), 32'd1);
        // Fall is sampled on the first edge, then FLUSH lasts FC edges.
        check("frame_done_latency", 32'(done_ticks), 32'(FC + 1));
        tick();
        tick();
    endtask

    initial begin
        iRST = 1'b0; iEN = 1'b0; iFVAL = 1'b0; iWIN_DVAL = 1'b0;
        iMODE_WR = 1'b0; iMODE_REQ = 2'd0;
        clear_tally();
        #2 iRST = 1'b1;
        repeat (3) @(posedge iCLK);
        #1 iRST = 1'b0;
        check("rst_mode", 32'(oMODE), 32'd0);
        check("rst_cnt", 32'(oFRAME_CNT), 32'd0);
        check("rst_err", 32'(oERR), 32'd0);
        check("rst_proc_en", 32'(oPROC_EN), 32'd0);

        iEN = 1'b1;
        tick();
        tick();

        // Frame 1: full frame, pending mode 2 written mid-frame.
        run_frame(12, 2, -1, -1);
        check("f1_mode", 32'(mode_seen), 32'd0);
        check("f1_dval", 32'(n_dval), 32'd2);
        check("f1_border", 32'(n_border), 32'd10);
        if (coords.size() == 2) begin
            check("f1_coord0", 32'(coords[0]), {10'd0, 11'd2, 11'd2});
            check("f1_coord1", 32'(coords[1]), {10'd0, 11'd3, 11'd2});
        end
        check("f1_cnt", 32'(oFRAME_CNT), 32'd1);
        check("f1_err", 32'(oERR), 32'd0);

        // Frame 2: mode 1 written on the rise edge goes to frame 3.
        run_frame(12, -1, 1, -1);
        check("f2_mode", 32'(mode_seen), 32'd2);
        check("f2_dval", 32'(n_dval), 32'd2);
        check("f2_cnt", 32'(oFRAME_CNT), 32'd2);
        check("f2_err", 32'(oERR), 32'd0);

        iMODE_WR = 1'b1; iMODE_REQ = 2'd3;
        tick();
        iMODE_WR = 1'b0;
        tick();

        // Frame 3: short frame, 7 strobes all in the border.
        run_frame(7, -1, -1, -1);
        check("f3_mode", 32'(mode_seen), 32'd1);
        check("f3_dval", 32'(n_dval), 32'd0);
        check("f3_border", 32'(n_border), 32'd7);
        check("f3_err_pre", 32'(err_pre), 32'd0);
        check("f3_cnt", 32'(oFRAME_CNT), 32'd3);
        check("f3_err", 32'(oERR), 32'd1);

        // Frame 4: good frame, error stays sticky.
        run_frame(12, -1, -1, -1);
        check("f4_dval", 32'(n_dval), 32'd2);
        check("f4_cnt", 32'(oFRAME_CNT), 32'd4);
        check("f4_err", 32'(oERR), 32'd1);

        // Mid-frame reset with iFVAL held high: no restart until a fresh rise.
        iFVAL = 1'b1;
        tick();
        iWIN_DVAL = 1'b1;
        repeat (3) tick();
        iWIN_DVAL = 1'b0;
        #2 iRST = 1'b1;
        tick();
        tick();
        check("mid_rst_cnt", 32'(oFRAME_CNT), 32'd0);
        check("mid_rst_err", 32'(oERR), 32'd0);
        iRST = 1'b0;
        clear_tally();
        iWIN_DVAL = 1'b1;
        repeat (4) tick();
        iWIN_DVAL = 1'b0;
        check("post_rst_outputs", 32'(n_dval + n_border), 32'd0);
        check("post_rst_proc_en", 32'(pe_seen), 32'd0);
        iFVAL = 1'b0;
        tick();
        tick();

        // Overflow frame: strobes 13-14 dropped, error raised before frame end.
        run_frame(14, -1, -1, -1);
        check("f5_mode", 32'(mode_seen), 32'd0);
        check("f5_dval", 32'(n_dval), 32'd2);
        check("f5_border", 32'(n_border), 32'd10);
        check("f5_err_pre", 32'(err_pre), 32'd1);
        check("f5_cnt", 32'(oFRAME_CNT), 32'd1);

        // iEN dropped at row 1: frame completes, then a new rise is ignored.
        run_frame(12, -1, -1, 4);
        check("f6_dval", 32'(n_dval), 32'd2);
        check("f6_cnt", 32'(oFRAME_CNT), 32'd2);
        clear_tally();
        iFVAL = 1'b1;
        tick();
        iWIN_DVAL = 1'b1;
        repeat (3) tick();
        iWIN_DVAL = 1'b0;
        iFVAL = 1'b0;
        tick();
        check("idle_proc_en", 32'(pe_seen), 32'd0);
        check("idle_outputs", 32'(n_dval + n_border), 32'd0);
        check("idle_cnt", 32'(oFRAME_CNT), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/image_proc_ctrl.md
Name: image_proc_ctrl

Overview:
- Frame-level sequencer for the grayscale/Sobel image processing datapath, sitting between the camera capture stage and the processing pipeline.
- Arms on enable and aligns start to the rising edge of frame-valid; commits a pending display-mode request only at frame boundaries.
- Tracks window row/column, masks the invalid 3x3 border outputs, drains pipeline latency after frame end, and reports per-frame status.

Parameters:
IMG_W, 640, processed columns per row (window-valid pulses per row)
IMG_H, 480, processed rows per frame
KSIZE, 3, kernel size; first KSIZE-1 rows/cols of each frame are border
FLUSH_CYC, 4, cycles held in FLUSH after iFVAL falls (pipeline drain)

Ports:
iCLK  in  1  clock
iRST  in  1  asynchronous reset, active-high
iEN  in  1  processing enable (level)
iFVAL  in  1  frame valid from capture
iWIN_DVAL  in  1  window-valid strobe from datapath
iMODE_WR  in  1  mode write strobe
iMODE_REQ  in  2  requested mode: 0 bypass, 1 gray, 2 sobel; 3 illegal
oMODE  out  2  committed mode for current frame
oPROC_EN  out  1  datapath enable; high in ACTIVE and FLUSH
oOUT_DVAL  out  1  masked output valid, registered
oBORDER  out  1  registered; high for window strobes that were masked
oCOL  out  11  column of current window strobe, registered with oOUT_DVAL
oROW  out  11  row of current window strobe
oFRAME_DONE  out  1  one-cycle pulse on FLUSH exit
oFRAME_CNT  out  16  completed frames, wraps at 65535->0
oERR  out  1  sticky: short frame or overflow; cleared only by reset

Behaviour:
- Reset (async, iRST=1): state IDLE; all outputs 0 (oMODE=0, oFRAME_CNT=0, oERR=0); pending mode 0; fval_d=1, so iFVAL already high at release is not seen as a frame start.
- fval_rise = iFVAL & ~fval_d; fval_fall = ~iFVAL & fval_d.
- FSM:
  - IDLE: go to ARMED when iEN=1.
  - ARMED: if iEN=0, go to IDLE. On fval_rise, go to ACTIVE, load oMODE <= pending, and clear col/row.
  - ACTIVE: on fval_fall, go to FLUSH and load the flush counter with FLUSH_CYC-1.
  - FLUSH: decrement each cycle. At 0, pulse oFRAME_DONE and increment oFRAME_CNT. Set oERR if the accepted strobe count is below IMG_W*IMG_H. Next state is ARMED if iEN=1, else IDLE.
  - iEN=0 during ACTIVE/FLUSH does not abort; the frame completes.
- Mode: iMODE_WR with REQ 0..2 writes pending (last write wins); REQ=3 is ignored. A write in the same cycle as fval_rise does not reach this frame; it applies next frame.
- Counting: in ACTIVE or FLUSH, each iWIN_DVAL advances col. When col=IMG_W-1, col wraps to 0 and row increments.
  - At row=IMG_H-1, col=IMG_W-1 the frame is full. Further strobes are dropped (no oOUT_DVAL, no oBORDER) and set oERR.
  - Strobes in IDLE/ARMED are ignored.
- Output (1-cycle latency from iWIN_DVAL):
  - oOUT_DVAL = accepted & col>=KSIZE-1 & row>=KSIZE-1.
  - oBORDER = accepted & ~that condition.
  - oCOL/oROW hold the strobe's coordinates and keep their value otherwise.
- Mid-frame reset: return to IDLE. The in-progress frame is never counted; next start requires a fresh rising edge.

Test Plan (IMG_W=4, IMG_H=3, KSIZE=3, FLUSH_CYC=2):
1. Release reset, iEN=1, iFVAL 0->1, 12 iWIN_DVAL, iFVAL->0 -> exactly 2 oOUT_DVAL at (col,row)=(2,2),(3,2); 10 oBORDER; oFRAME_DONE 2 cycles after fall; oFRAME_CNT=1; oERR=0.
2. iMODE_WR REQ=2 during frame, REQ=1 in same cycle as next fval_rise -> oMODE=2 for second frame, 1 for third; REQ=3 write leaves pending unchanged.
3. Only 7 strobes then iFVAL falls -> oFRAME_DONE pulses, oFRAME_CNT increments, oERR=1 and stays 1 through later good frames.
4. 14 strobes in one frame -> strobes 13-14 produce neither oOUT_DVAL nor oBORDER; oERR=1.
5. iRST held with iFVAL=1, release mid-frame -> stays ARMED, no outputs until iFVAL falls and rises again.
6. iEN dropped at row 1 -> frame completes, oFRAME_DONE pulses, FSM to IDLE; next fval_rise ignored, oPROC_EN=0.
